tx_grant_scheduler: RTL and testbench
=====================================

Name: tx_grant_scheduler

Overview:
- Drains the Tx sequence recorder one entry at a time, oldest first.
- Each entry is a source ID. The block checks PCIe flow-control credits for that source's TLP class.
- When credits are sufficient, it issues an exclusive grant to that source and holds it until the source reports the TLP is fully transferred.
- Sits between the sequence recorder and the Tx TLP buffer/DLL hand-off. It is the single point that serialises A2P_1, A2P_2, Master and Rx Router traffic onto the link.

Parameters:
- HCW, 8, header credit counter width.
- DCW, 12, data credit width (16-byte units) for availability and request length.
- TIMEOUT, 1024, max GRANT cycles without src_done before abort.

Ports:
- clk  in  1  clock.
- arst  in  1  synchronous, active-high reset.
- seq_empty  in  1  sequence recorder empty.
- seq_rd_data  in  3  head source ID. Valid the cycle after seq_rd_en.
- seq_rd_en  out  1  pop one entry.
- fc_ph_avail  in  HCW  posted header credits.
- fc_pd_avail  in  DCW  posted data credits.
- fc_nph_avail  in  HCW  non-posted header credits.
- fc_cplh_avail  in  HCW  completion header credits.
- fc_cpld_avail  in  DCW  completion data credits.
- src_dcred  in  5*DCW  per-source data credit request. Slice i belongs to source ID i+1.
- src_done  in  5  per-source end-of-TLP pulse. Bit i belongs to source ID i+1.
- grant  out  5  one-hot grant. Bit i belongs to source ID i+1.
- fc_consume_valid  out  1  one-cycle credit consume pulse.
- fc_consume_type  out  2  0=P, 1=NP, 2=CPL.
- fc_consume_data  out  DCW  data credits consumed.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on grant abort.
- invalid_id_err  out  1  one-cycle pulse on bad ID.

Behaviour:
- Source ID encoding and class mapping:
  - 0 NO_SOURCE.
  - 1 A2P_1 → NP.
  - 2 A2P_2 → P.
  - 3 MASTER → CPL.
  - 4 RX_ROUTER_CFG → CPL.
  - 5 RX_ROUTER_ERR → P (message).
  - 6 and 7 are invalid.
- Reset (arst high at clk edge):
  - state=IDLE; all outputs 0; latched ID and length cleared; timeout counter cleared.
  - Reset during GRANT drops grant at that edge. The entry is discarded, not re-queued.
- All outputs are registered.
- FSM states: IDLE, FETCH, CHECK, GRANT.
- IDLE:
  - If !seq_empty: seq_rd_en=1 for exactly one cycle, then go to FETCH.
  - Otherwise stay in IDLE with seq_rd_en=0.
- FETCH: latch seq_rd_data, then go to CHECK.
- CHECK, with invalid ID (0, 6, 7): invalid_id_err pulse; go to IDLE; no grant, no consume.
- CHECK, credit rules:
  - P: fc_ph_avail>=1 and fc_pd_avail>=req.
  - NP: fc_nph_avail>=1; data is ignored and fc_consume_data=0.
  - CPL: fc_cplh_avail>=1 and fc_cpld_avail>=req.
  - req is the src_dcred slice of the latched ID, sampled in CHECK.
  - All comparisons are unsigned.
  - req=0 is legal and needs only a header credit.
- CHECK, insufficient credits: stay in CHECK, re-evaluating every cycle. No timeout applies here. Strict in-order: no bypass of the head entry.
- CHECK → GRANT, at the transition edge:
  - grant bit is set.
  - fc_consume_valid=1 for exactly one cycle, with type and req latched.
  - Timeout counter is cleared.
- Latency: from seq_empty falling while in IDLE to grant high is 3 cycles minimum (IDLE, FETCH, CHECK).
- GRANT, completion:
  - grant is held stable and one-hot.
  - src_done on the granted bit → grant cleared at the next edge; go to IDLE.
  - src_done on other bits is ignored; it is also ignored in all other states.
- GRANT, timeout:
  - Counter increments each GRANT cycle.
  - When it reaches TIMEOUT-1 without done: timeout_err pulse, grant cleared, go to IDLE.
  - Consumed credits are not returned.
- done and timeout in the same cycle: done wins, no timeout_err.
- Back-to-back: a new entry is popped only after returning to IDLE, so at most one entry is in flight. There is at least one idle cycle between consecutive grants.
- busy equals state!=IDLE.

Test Plan:
1. Reset, then push ID 2 with src_dcred[slice1]=4, fc_ph=2, fc_pd=10.
   → seq_rd_en pulse; 3 cycles later grant=5'b00010 and fc_consume_valid with type=0, data=4.
   → src_done[1] pulse; grant=0 next cycle; busy=0.
2. Push ID 3 with req=8, fc_cpld=5, fc_cplh=1.
   → Stays in CHECK, grant=0.
   → Raise fc_cpld to 8; grant=5'b00100 on the next cycle; consume type=2, data=8.
3. Push IDs 1 then 4, fc_nph=1.
   → grant 5'b00001 with consume type=1, data=0; after done, ≥1 idle cycle.
   → Then grant 5'b01000.
   → Order is preserved; grant is never two-hot.
4. Grant ID 5 with TIMEOUT=16 and no src_done.
   → timeout_err pulse after 16 GRANT cycles; grant=0; next entry is processed.
   → Repeat with done on the last cycle: no timeout_err.
5. Feed IDs 0 and 7.
   → invalid_id_err pulse each time; no grant; no fc_consume_valid.
6. Assert arst mid-GRANT and wiggle src_done of a non-granted source.
   → All outputs 0 at the reset edge; state IDLE.
   → Stray done bits have no effect in any state.

Source files
------------

// File: rtl/tx_grant_scheduler.sv
// tx_grant_scheduler: pops source IDs in order, checks flow-control credits and holds an exclusive grant until done or timeout
module tx_grant_scheduler #(
  parameter int HCW = 8,
  parameter int DCW = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           seq_empty,
  input  logic [2:0]     seq_rd_data,
  output logic           seq_rd_en,
  input  logic [HCW-1:0] fc_ph_avail,
  input  logic [DCW-1:0] fc_pd_avail,
  input  logic [HCW-1:0] fc_nph_avail,
  input  logic [HCW-1:0] fc_cplh_avail,
  input  logic [DCW-1:0] fc_cpld_avail,
  input  logic [5*DCW-1:0] src_dcred,
  input  logic [4:0]     src_done,
  output logic [4:0]     grant,
  output logic           fc_consume_valid,
  output logic [1:0]     fc_consume_type,
  output logic [DCW-1:0] fc_consume_data,
  output logic           busy,
  output logic           timeout_err,
  output logic           invalid_id_err
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, FETCH, CHECK, GRANT} state_t;
  state_t state;
  logic [2:0] id_q;
  logic [CW-1:0] cnt;
  logic [DCW-1:0] req;
  logic [1:0] cls;
  logic valid_id, ok;
  always_comb begin
    req = '0;
    for (int i = 0; i < 5; i++)
      if (id_q == 3'(i + 1)) req = src_dcred[i*DCW +: DCW];
    valid_id = id_q != 3'd0 && id_q <= 3'd5;
    cls = id_q == 3'd1 ? 2'd1 : (id_q == 3'd3 || id_q == 3'd4) ? 2'd2 : 2'd0;
    ok = cls == 2'd1 ? fc_nph_avail != '0 :
         cls == 2'd2 ? fc_cplh_avail != '0 && fc_cpld_avail >= req :
                       fc_ph_avail != '0 && fc_pd_avail >= req;
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      id_q <= '0;
      cnt <= '0;
      seq_rd_en <= 1'b0;
      grant <= '0;
      fc_consume_valid <= 1'b0;
      fc_consume_type <= '0;
      fc_consume_data <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      invalid_id_err <= 1'b0;
    end else begin
      seq_rd_en <= 1'b0;
      fc_consume_valid <= 1'b0;
      timeout_err <= 1'b0;
      invalid_id_err <= 1'b0;
      case (state)
        IDLE: if (!seq_empty) begin
          seq_rd_en <= 1'b1;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          id_q <= seq_rd_data;
          state <= CHECK;
        end
        CHECK: if (!valid_id) begin
          invalid_id_err <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else if (ok) begin
          grant <= 5'd1 << (id_q - 3'd1);
          fc_consume_valid <= 1'b1;
          fc_consume_type <= cls;
          fc_consume_data <= cls == 2'd1 ? '0 : req;
          cnt <= '0;
          state <= GRANT;
        end
        GRANT: if ((src_done & grant) != '0) begin
          grant <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end else if (cnt == TMAX) begin
          timeout_err <= 1'b1;
          grant <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_grant_scheduler.sv
// tb_tx_grant_scheduler: directed checks of ordering, credit gating, timeout, invalid IDs and reset
module tb_tx_grant_scheduler;
  localparam int HCW = 8, DCW = 12, TIMEOUT = 16;
  logic clk = 0, arst = 1;
  logic seq_empty, seq_rd_en;
  logic [2:0] seq_rd_data;
  logic [HCW-1:0] fc_ph_avail = 0, fc_nph_avail = 0, fc_cplh_avail = 0;
  logic [DCW-1:0] fc_pd_avail = 0, fc_cpld_avail = 0;
  logic [5*DCW-1:0] src_dcred = 0;
  logic [4:0] src_done = 0, grant;
  logic fc_consume_valid, busy, timeout_err, invalid_id_err;
  logic [1:0] fc_consume_type;
  logic [DCW-1:0] fc_consume_data;
  logic [2:0] mem [0:7];
  int wr_ptr = 0, rd_ptr = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign seq_empty = rd_ptr == wr_ptr;
  assign seq_rd_data = mem[rd_ptr[2:0]];
  always @(posedge clk) if (seq_rd_en && !seq_empty) rd_ptr <= rd_ptr + 1;
  tx_grant_scheduler #(.HCW(HCW), .DCW(DCW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst(arst), .seq_empty(seq_empty), .seq_rd_data(seq_rd_data),
    .seq_rd_en(seq_rd_en), .fc_ph_avail(fc_ph_avail), .fc_pd_avail(fc_pd_avail),
    .fc_nph_avail(fc_nph_avail), .fc_cplh_avail(fc_cplh_avail), .fc_cpld_avail(fc_cpld_avail),
    .src_dcred(src_dcred), .src_done(src_done), .grant(grant),
    .fc_consume_valid(fc_consume_valid), .fc_consume_type(fc_consume_type),
    .fc_consume_data(fc_consume_data), .busy(busy), .timeout_err(timeout_err),
    .invalid_id_err(invalid_id_err));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [2:0] id);
    mem[wr_ptr[2:0]] = id;
    wr_ptr++;
  endtask
  task automatic chk_consume(input string tag, input logic [1:0] t, input logic [DCW-1:0] d);
    chk({tag, "_cv"}, {31'b0, fc_consume_valid}, 1);
    chk({tag, "_type"}, {30'b0, fc_consume_type}, {30'b0, t});
    chk({tag, "_data"}, {20'b0, fc_consume_data}, {20'b0, d});
  endtask
  always @(negedge clk) if (!arst) chk("onehot", {31'b0, $countones(grant) <= 1}, 1);
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end
  initial begin
    step(2);
    chk("reset_outs", {8'b0, seq_rd_en, grant, fc_consume_valid, fc_consume_type, fc_consume_data,
        busy, timeout_err, invalid_id_err}, 0);
    arst = 0;
    step(1);
    // Test 1: P grant for ID 2
    src_dcred[1*DCW +: DCW] = 4; fc_ph_avail = 2; fc_pd_avail = 10;
    push(2);
    step(1);
    chk("t1_rd_en", {31'b0, seq_rd_en}, 1);
    chk("t1_busy", {31'b0, busy}, 1);
    step(1);
    chk("t1_rd_en_pulse", {31'b0, seq_rd_en}, 0);
    chk("t1_nogrant_check", {27'b0, grant}, 0);
    step(1);
    chk("t1_grant", {27'b0, grant}, 5'b00010);
    chk_consume("t1", 2'd0, 4);
    step(1);
    chk("t1_cv_pulse", {31'b0, fc_consume_valid}, 0);
    src_done = 5'b00010;
    step(1);
    src_done = 0;
    chk("t1_released", {27'b0, grant}, 0);
    chk("t1_idle", {31'b0, busy}, 0);
    // Test 2: CPL blocked until data credits suffice
    src_dcred[2*DCW +: DCW] = 8; fc_cplh_avail = 1; fc_cpld_avail = 5;
    push(3);
    step(3);
    chk("t2_blocked", {27'b0, grant}, 0);
    chk("t2_busy", {31'b0, busy}, 1);
    step(4);
    chk("t2_still_blocked", {27'b0, grant}, 0);
    fc_cpld_avail = 8;
    step(1);
    chk("t2_grant", {27'b0, grant}, 5'b00100);
    chk_consume("t2", 2'd2, 8);
    src_done = 5'b00100;
    step(1);
    src_done = 0;
    chk("t2_released", {27'b0, grant}, 0);
    // Test 3: order preserved, NP consumes no data
    fc_nph_avail = 1; src_dcred[0*DCW +: DCW] = 7; src_dcred[3*DCW +: DCW] = 3;
    push(1); push(4);
    step(3);
    chk("t3_grant1", {27'b0, grant}, 5'b00001);
    chk_consume("t3a", 2'd1, 0);
    src_done = 5'b00001;
    step(1);
    src_done = 0;
    chk("t3_gap_grant", {27'b0, grant}, 0);
    chk("t3_gap_busy", {31'b0, busy}, 0);
    step(3);
    chk("t3_grant4", {27'b0, grant}, 5'b01000);
    chk_consume("t3b", 2'd2, 3);
    src_done = 5'b01000;
    step(1);
    src_done = 0;
    // Test 4: timeout abort, then next entry
    src_dcred[4*DCW +: DCW] = 2;
    push(5); push(2);
    step(3);
    chk("t4_grant5", {27'b0, grant}, 5'b10000);
    chk_consume("t4", 2'd0, 2);
    step(15);
    chk("t4_held_last", {27'b0, grant}, 5'b10000);
    chk("t4_no_early_to", {31'b0, timeout_err}, 0);
    step(1);
    chk("t4_to_err", {31'b0, timeout_err}, 1);
    chk("t4_to_drop", {27'b0, grant}, 0);
    step(1);
    chk("t4_to_pulse", {31'b0, timeout_err}, 0);
    step(2);
    chk("t4_next", {27'b0, grant}, 5'b00010);
    src_done = 5'b00010;
    step(1);
    src_done = 0;
    push(5);
    step(3);
    chk("t4b_grant5", {27'b0, grant}, 5'b10000);
    step(15);
    src_done = 5'b10000;
    step(1);
    src_done = 0;
    chk("t4b_done_wins", {31'b0, timeout_err}, 0);
    chk("t4b_released", {27'b0, grant}, 0);
    // Test 5: invalid IDs
    push(0); push(7);
    step(3);
    chk("t5_inv0", {31'b0, invalid_id_err}, 1);
    chk("t5_inv0_cv", {31'b0, fc_consume_valid}, 0);
    chk("t5_inv0_busy", {31'b0, busy}, 0);
    step(1);
    chk("t5_inv_pulse", {31'b0, invalid_id_err}, 0);
    step(2);
    chk("t5_inv7", {31'b0, invalid_id_err}, 1);
    chk("t5_inv7_grant", {27'b0, grant}, 0);
    // Test 6: stray done ignored, reset mid-grant
    push(2);
    step(3);
    chk("t6_grant", {27'b0, grant}, 5'b00010);
    src_done = 5'b11101;
    step(2);
    chk("t6_stray_ignored", {27'b0, grant}, 5'b00010);
    arst = 1;
    step(1);
    chk("t6_reset_outs", {8'b0, seq_rd_en, grant, fc_consume_valid, fc_consume_type, fc_consume_data,
        busy, timeout_err, invalid_id_err}, 0);
    arst = 0;
    step(3);
    chk("t6_idle_grant", {27'b0, grant}, 0);
    chk("t6_idle_busy", {31'b0, busy}, 0);
    src_done = 0;
    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
